// File: rtl/vga_fifo_pkg.sv
// Shared constants for the VGA scan-line FIFOs: depth derivation and default thresholds.
package vga_fifo_pkg;

   localparam int AE_LVL_DEF = 4;
   localparam int AF_MARGIN  = 4;

   function automatic int fifo_depth(input int awidth);
      return 1 << awidth;
   endfunction

endpackage

// File: rtl/generic_dpram.sv
// Simple dual-port RAM: synchronous write port, registered read port, no reset on contents.
module generic_dpram #(
   parameter int AW = 7,
   parameter int DW = 16
) (
   input  logic          rclk,
   input  logic          rce,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] q,
   input  logic          wclk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] d
);

   logic [DW-1:0] mem [2**AW];

   always_ff @(posedge wclk) begin
      if (we) mem[waddr] <= d;
   end

   always_ff @(posedge rclk) begin
      if (rce) q <= mem[raddr];
   end

endmodule

// File: rtl/vga_fifo_sc.sv
// Single-clock FIFO with fill count and registered status flags.
// Optional sticky overflow/underflow outputs are enabled by defining VGA_FIFO_ERR_EN.
module vga_fifo_sc
   import vga_fifo_pkg::*;
#(
   parameter int AWIDTH = 7,
   parameter int DWIDTH = 16,
   parameter int AE_LVL = AE_LVL_DEF,
   parameter int AF_LVL = fifo_depth(AWIDTH) - AF_MARGIN
) (
   input  logic              clk,
   input  logic              arst,
   input  logic              sclr,
   input  logic              wreq,
   input  logic [DWIDTH-1:0] d,
   input  logic              rreq,
   output logic [DWIDTH-1:0] q,
   output logic [AWIDTH:0]   nword,
   output logic              empty,
   output logic              full,
   output logic              aempty,
   output logic              afull
`ifdef VGA_FIFO_ERR_EN
   ,
   output logic              ovf,
   output logic              udf
`endif
);

   localparam int DEPTH = fifo_depth(AWIDTH);

   typedef logic [AWIDTH:0] ptr_t;

   localparam ptr_t DEPTH_C = ptr_t'(DEPTH);
   localparam ptr_t ONE     = ptr_t'(1);

   ptr_t              wptr, rptr, nword_nxt;
   logic              wr_acc, rd_acc;
   logic              rd_vld_p1;
   logic [DWIDTH-1:0] ram_q, q_hold;

   assign wr_acc = wreq & ~full  & ~sclr;
   assign rd_acc = rreq & ~empty & ~sclr;

   always_comb begin
      nword_nxt = nword;
      if (sclr)                 nword_nxt = '0;
      else if (wr_acc & ~rd_acc) nword_nxt = nword + ONE;
      else if (rd_acc & ~wr_acc) nword_nxt = nword - ONE;
   end

   // Stage p0: pointers, count and flags all derive from nword_nxt, so they move together
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         wptr   <= '0;
         rptr   <= '0;
         nword  <= '0;
         empty  <= 1'b1;
         aempty <= 1'b1;
         full   <= 1'b0;
         afull  <= 1'b0;
      end else begin
         if (sclr) begin
            wptr <= '0;
            rptr <= '0;
         end else begin
            if (wr_acc) wptr <= wptr + ONE;
            if (rd_acc) rptr <= rptr + ONE;
         end
         nword  <= nword_nxt;
         empty  <= (nword_nxt == '0);
         full   <= (nword_nxt == DEPTH_C);
         aempty <= (int'(nword_nxt) <= AE_LVL);
         afull  <= (int'(nword_nxt) >= AF_LVL);
      end
   end

   // Stage p1: RAM output is valid only the cycle after an accepted read; otherwise q holds
   always_ff @(posedge clk or posedge arst) begin
      if (arst) rd_vld_p1 <= 1'b0;
      else      rd_vld_p1 <= rd_acc;
   end

   always_ff @(posedge clk) begin
      if (rd_vld_p1) q_hold <= ram_q;
   end

   assign q = rd_vld_p1 ? ram_q : q_hold;

`ifdef VGA_FIFO_ERR_EN
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         ovf <= 1'b0;
         udf <= 1'b0;
      end else if (sclr) begin
         ovf <= 1'b0;
         udf <= 1'b0;
      end else begin
         if (wreq & full)  ovf <= 1'b1;
         if (rreq & empty) udf <= 1'b1;
      end
   end
`endif

   generic_dpram #(
      .AW(AWIDTH),
      .DW(DWIDTH)
   ) u_ram (
      .rclk  (clk),
      .rce   (1'b1),
      .raddr (rptr[AWIDTH-1:0]),
      .q     (ram_q),
      .wclk  (clk),
      .we    (wr_acc),
      .waddr (wptr[AWIDTH-1:0]),
      .d     (d)
   );

endmodule

// File: tb/tb_vga_fifo_sc.sv
// Randomised queue-model bench for vga_fifo_sc at AWIDTH=3, plus directed literal checks.
module tb_vga_fifo_sc;

   localparam int AW = 3;
   localparam int DW = 16;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          arst, sclr, wreq, rreq;
   logic [DW-1:0] d, q;
   logic [AW:0]   nword;
   logic          empty, full, aempty, afull;
`ifdef VGA_FIFO_ERR_EN
   logic          ovf, udf;
`endif

   int n_vec = 0;
   int n_err = 0;

   vga_fifo_sc #(.AWIDTH(AW), .DWIDTH(DW)) dut (
      .clk(clk), .arst(arst), .sclr(sclr), .wreq(wreq), .d(d), .rreq(rreq),
      .q(q), .nword(nword), .empty(empty), .full(full), .aempty(aempty), .afull(afull)
`ifdef VGA_FIFO_ERR_EN
      , .ovf(ovf), .udf(udf)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: a queue of stored words plus the last word read out.
   logic [DW-1:0] mq[$];
   logic [DW-1:0] exp_q;
   bit            q_known = 0;
   bit            e_ovf = 0, e_udf = 0;

   always begin
      logic s_w, s_r, s_s, s_a;
      logic [DW-1:0] s_d;
      bit wa, ra;
      int sz;
      @(posedge clk);
      s_w = wreq; s_r = rreq; s_s = sclr; s_a = arst; s_d = d;
      #1;
      if (s_a || arst) begin
         mq.delete(); q_known = 0; e_ovf = 0; e_udf = 0;
      end else if (s_s) begin
         mq.delete(); e_ovf = 0; e_udf = 0;
      end else begin
         sz = mq.size();
         wa = s_w && (sz < DEPTH);
         ra = s_r && (sz > 0);
         if (s_w && !wa) e_ovf = 1;
         if (s_r && !ra) e_udf = 1;
         if (ra) begin exp_q = mq.pop_front(); q_known = 1; end
         if (wa) mq.push_back(s_d);
      end
      if (!arst) begin
         sz = mq.size();
         chk("nword",  32'(nword),  32'(sz));
         chk("empty",  32'(empty),  32'(sz == 0));
         chk("full",   32'(full),   32'(sz == DEPTH));
         chk("aempty", 32'(aempty), 32'(sz <= 4));
         chk("afull",  32'(afull),  32'(sz >= DEPTH - 4));
         if (q_known) chk("q", 32'(q), 32'(exp_q));
`ifdef VGA_FIFO_ERR_EN
         chk("ovf", 32'(ovf), 32'(e_ovf));
         chk("udf", 32'(udf), 32'(e_udf));
`endif
      end
   end

   task automatic step(input logic w, input logic [DW-1:0] dv, input logic r, input logic s);
      @(negedge clk);
      wreq = w; d = dv; rreq = r; sclr = s;
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      step(1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic chk_reset_flags(input string tag);
      chk({tag, "_nword"},  32'(nword),  0);
      chk({tag, "_empty"},  32'(empty),  1);
      chk({tag, "_aempty"}, 32'(aempty), 1);
      chk({tag, "_full"},   32'(full),   0);
      chk({tag, "_afull"},  32'(afull),  0);
   endtask

   initial begin
      arst = 1'b1; sclr = 1'b0; wreq = 1'b0; rreq = 1'b0; d = '0;
      #3;
      chk_reset_flags("rst");
      @(negedge clk); @(negedge clk);
      arst = 1'b0;
      idle();

      // fill to full, then a dropped ninth write
      for (int i = 1; i <= 9; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
      chk("fill_nword", 32'(nword), 8);
      chk("fill_full",  32'(full),  1);
`ifdef VGA_FIFO_ERR_EN
      chk("fill_ovf", 32'(ovf), 1);
`endif

      // drain in order; q valid right after each read edge
      for (int i = 1; i <= 8; i++) begin
         step(1'b0, '0, 1'b1, 1'b0);
         chk("drain_q", 32'(q), 32'(i));
      end
      chk("drain_empty", 32'(empty), 1);
      idle();
      chk("hold_q", 32'(q), 32'h8);

      // read on empty with a simultaneous write
      step(1'b1, 16'hABCD, 1'b1, 1'b0);
      chk("ew_nword", 32'(nword), 1);
      step(1'b0, '0, 1'b1, 1'b0);
      chk("ew_q", 32'(q), 32'hABCD);
      idle();

      // steady nword=3 with read+write across pointer wrap
      for (int i = 0; i < 3; i++) step(1'b1, DW'(16'h100 + i), 1'b0, 1'b0);
      for (int i = 3; i < 13; i++) begin
         step(1'b1, DW'(16'h100 + i), 1'b1, 1'b0);
         chk("wrap_nword", 32'(nword), 3);
         chk("wrap_q", 32'(q), 32'(16'h100 + i - 3));
      end

      // sclr has priority over a write
      step(1'b1, 16'h55, 1'b0, 1'b0);
      step(1'b1, 16'h56, 1'b0, 1'b0);
      chk("pre_clr_nword", 32'(nword), 5);
      step(1'b1, 16'h57, 1'b0, 1'b1);
      chk("clr_nword", 32'(nword), 0);
      chk("clr_empty", 32'(empty), 1);
      idle();
      chk("post_clr_nword", 32'(nword), 0);

      // randomised traffic
      for (int i = 0; i < 1500; i++) begin
         logic w, r, s;
         w = ($urandom_range(0, 99) < 55);
         r = ($urandom_range(0, 99) < 50);
         s = ($urandom_range(0, 99) < 2);
         step(w, DW'($urandom), r, s);
      end

      // asynchronous reset mid-operation discards contents
      for (int i = 0; i < 4; i++) step(1'b1, DW'(16'h700 + i), 1'b0, 1'b0);
      @(negedge clk);
      wreq = 1'b0; rreq = 1'b0; sclr = 1'b0;
      #2 arst = 1'b1;
      #1 chk_reset_flags("midrst");
      @(posedge clk);
      #2 chk_reset_flags("midrst_edge");
      @(negedge clk);
      arst = 1'b0;
      step(1'b1, 16'h1234, 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      chk("post_rst_q", 32'(q), 32'h1234);
      chk("post_rst_empty", 32'(empty), 1);
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/vga_fifo_sc.md
VGA_FIFO_SC -- requirements
Module: vga_fifo_sc

Interface
REQ-001 SHALL have parameter AWIDTH, default 7, address width; depth DEPTH = 2**AWIDTH entries.
REQ-002 SHALL have parameter DWIDTH, default 16, data width in bits.
REQ-003 SHALL have parameter AE_LVL, default 4, almost-empty threshold in words.
REQ-004 SHALL have parameter AF_LVL, default DEPTH-4, almost-full threshold in words.
REQ-005 SHALL have port clk  input  1  the single clock; all logic is rising-edge clocked.
REQ-006 SHALL have port arst  input  1  reset, asynchronous and active-high.
REQ-007 SHALL have port sclr  input  1  synchronous clear, active-high.
REQ-008 SHALL have port wreq  input  1  write request.
REQ-009 SHALL have port d  input  DWIDTH  write data.
REQ-010 SHALL have port rreq  input  1  read request.
REQ-011 SHALL have port q  output  DWIDTH  read data.
REQ-012 SHALL have port nword  output  AWIDTH+1  fill level, 0..DEPTH.
REQ-013 SHALL have ports empty, full, aempty and afull  output  1  each, status flags.

Function
REQ-014 SHALL keep read and write pointers of AWIDTH+1 bits; the MSB distinguishes full from empty; the pointers wrap modulo 2*DEPTH.
REQ-015 SHALL accept a write on a clk edge iff wreq=1, full=0 and sclr=0; an accepted write stores d at wptr and increments wptr.
REQ-016 SHALL accept a read on a clk edge iff rreq=1, empty=0 and sclr=0; an accepted read increments rptr.
REQ-017 SHALL present the word addressed by an accepted read on q one cycle after that read; q SHALL hold its value otherwise.
REQ-018 SHALL ignore a write when full=1, even if a read is accepted on the same edge.
REQ-019 SHALL ignore a read when empty=1, even if a write is accepted on the same edge.
REQ-020 SHALL update nword on every edge: +1 on write only, -1 on read only, unchanged when both or neither are accepted.
REQ-021 SHALL register the flags from next-state nword so they change on the same edge as nword, with no lag: empty=(nword==0), full=(nword==DEPTH), aempty=(nword<=AE_LVL), afull=(nword>=AF_LVL).
REQ-022 SHALL, on sclr=1, set both pointers and nword to 0, set empty=1, aempty=1, full=0 and afull=0 at the next edge, with priority over wreq and rreq.
REQ-023 SHALL allow all DEPTH entries to be used; there SHALL be no reserved margin slots.

Reset
REQ-024 SHALL, while arst=1, force the pointers and nword to 0, empty=1, aempty=1, full=0 and afull=0, regardless of clk.
REQ-025 SHALL leave q unspecified after reset until the first accepted read completes; memory contents are not cleared.
REQ-026 SHALL, on arst asserted mid-operation, discard all pending contents; the first read after release SHALL return only data written after release.

Configuration
REQ-027 SHALL, when VGA_FIFO_ERR_EN is defined, add outputs ovf and udf (1 bit each), reset to 0 by arst and sclr.
REQ-028 SHALL, with VGA_FIFO_ERR_EN defined, set ovf sticky-high on a write ignored because full=1, and set udf sticky-high on a read ignored because empty=1.
REQ-029 SHALL, when VGA_FIFO_ERR_EN is undefined, omit the ovf and udf ports and logic; all other behaviour SHALL be identical.

Structure
REQ-030 SHALL take DEPTH derivation and default threshold constants from the shared package vga_fifo_pkg.
REQ-031 SHALL instantiate the existing generic_dpram as its only sub-module, with clk on both ports, we driven by the accepted-write strobe, and read port always enabled.

Verification
REQ-032 SHALL verify that after arst pulse, with AWIDTH=3: nword=0, empty=1, aempty=1, full=0, afull=0.
REQ-033 SHALL verify that writing 8 words 0x0001..0x0008 with AWIDTH=3 then a 9th write gives full=1, nword=8, and the 9th word is dropped (ovf=1 when VGA_FIFO_ERR_EN is defined).
REQ-034 SHALL verify that 8 consecutive reads from the REQ-033 state return q=0x0001..0x0008, each one cycle after its rreq, ending with empty=1.
REQ-035 SHALL verify that with nword=3 and wreq=rreq=1 for 10 cycles, nword stays 3 and data order is preserved across pointer wrap.
REQ-036 SHALL verify that rreq on an empty FIFO with a simultaneous wreq of 0xABCD gives nword=1, and that the next read returns 0xABCD.
REQ-037 SHALL verify that sclr=1 with wreq=1 at nword=5 gives nword=0, empty=1, and no write accepted.
